edit_cursor_ctrl: RTL and testbench

EDIT_CURSOR_CTRL -- requirements
Module: edit_cursor_ctrl

---
 rtl/edit_cursor_ctrl_if.sv | 27 ++
 rtl/edit_cursor_ctrl.sv | 161 ++++++++++++++++
 tb/tb_edit_cursor_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/edit_cursor_ctrl_if.sv
// Bus bundle between the pointer/keyboard front end, the cursor controller
// and the downstream text buffer.
interface edit_cursor_ctrl_if;
  logic [9:0] MOUSE_X_POS;
  logic [8:0] MOUSE_Y_POS;
  logic       mouse_left;
  logic       key_valid;
  logic [2:0] key_code;
  logic       commit_ready;
  logic [8:0] writing_block_pos;
  logic       editing;
  logic       commit_valid;
  logic [8:0] commit_pos;
  logic       canvas_clear;

  // Stimulus side: drives pointer, keys and the text buffer's ready.
  modport master (
    output MOUSE_X_POS, MOUSE_Y_POS, mouse_left, key_valid, key_code, commit_ready,
    input  writing_block_pos, editing, commit_valid, commit_pos, canvas_clear
  );

  // Controller side.
  modport slave (
    input  MOUSE_X_POS, MOUSE_Y_POS, mouse_left, key_valid, key_code, commit_ready,
    output writing_block_pos, editing, commit_valid, commit_pos, canvas_clear
  );
endinterface

// File: rtl/edit_cursor_ctrl.sv
// Handwriting-cell cursor controller: a mouse click opens a cell, arrow keys
// move it, enter commits it to the text buffer and esc abandons it.
module edit_cursor_ctrl #(
  parameter int unsigned COLS = 20,
  parameter int unsigned ROWS = 15
) (
  input  logic              clk,
  input  logic              rst,
  edit_cursor_ctrl_if.slave bus
);

  localparam int unsigned XW = 5;
  localparam int unsigned YW = 4;
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDITING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [8:0]      cpos_q, cpos_d;
  logic            cv_q, cv_d;
  logic            edit_q, edit_d;
  logic            clr_q, clr_d;
  logic            prev_left_q;

  logic            click_c;
  logic [XW-1:0]   cell_x_c;
  logic [YW-1:0]   cell_y_c;
  logic            in_grid_c;
  logic            unused_c;

  assign cell_x_c  = bus.MOUSE_X_POS[9:5];
  assign cell_y_c  = bus.MOUSE_Y_POS[8:5];
  assign in_grid_c = (32'(cell_x_c) < COLS) && (32'(cell_y_c) < ROWS);
  assign click_c   = bus.mouse_left & ~prev_left_q;
  assign unused_c  = ^{bus.MOUSE_X_POS[4:0], bus.MOUSE_Y_POS[4:0]};

  // State and output registers; reset wins over any same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cpos_q      <= '0;
      cv_q        <= 1'b0;
      edit_q      <= 1'b0;
      clr_q       <= 1'b0;
      prev_left_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cpos_q      <= cpos_d;
      cv_q        <= cv_d;
      edit_q      <= edit_d;
      clr_q       <= clr_d;
      prev_left_q <= bus.mouse_left;
    end
  end

  // Next-state and next-output decode; one action per cycle at most.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cpos_d  = cpos_q;
    cv_d    = cv_q;
    clr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (click_c && in_grid_c) begin
          state_d = EDITING;
          x_d     = cell_x_c;
          y_d     = cell_y_c;
          clr_d   = 1'b1;
        end
      end

      EDITING: begin
        if (bus.key_valid) begin
          case (bus.key_code)
            KEY_UP: begin
              if (y_q != '0) begin
                y_d   = y_q - YW'(1);
                clr_d = 1'b1;
              end
            end
            KEY_DOWN: begin
              if (y_q != Y_MAX) begin
                y_d   = y_q + YW'(1);
                clr_d = 1'b1;
              end
            end
            KEY_LEFT: begin
              if (x_q != '0) begin
                x_d   = x_q - XW'(1);
                clr_d = 1'b1;
              end
            end
            KEY_RIGHT: begin
              if (x_q != X_MAX) begin
                x_d   = x_q + XW'(1);
                clr_d = 1'b1;
              end
            end
            KEY_ENTER: begin
              state_d = COMMIT;
              cv_d    = 1'b1;
              cpos_d  = {y_q, x_q};
            end
            KEY_ESC: begin
              state_d = IDLE;
              clr_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end

      COMMIT: begin
        if (cv_q && bus.commit_ready) begin
          state_d = IDLE;
          cv_d    = 1'b0;
          clr_d   = 1'b1;
          // Advance in raster order, wrapping from the last cell to the first.
          if (x_q == X_MAX) begin
            x_d = '0;
            y_d = (y_q == Y_MAX) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign edit_d = (state_d != IDLE);

  assign bus.writing_block_pos = {y_q, x_q};
  assign bus.editing           = edit_q;
  assign bus.commit_valid      = cv_q;
  assign bus.commit_pos        = cpos_q;
  assign bus.canvas_clear      = clr_q;

endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// Scoreboard bench for edit_cursor_ctrl: directed scenarios followed by
// randomized traffic, checked against a cell-index reference model.
module tb_edit_cursor_ctrl;

  localparam int COLS = 20;
  localparam int ROWS = 15;

  typedef struct packed {
    logic [8:0] pos;
    logic       ed;
    logic       cv;
    logic [8:0] cpos;
    logic       clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  edit_cursor_ctrl_if bus();

  edit_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 editing, 2 waiting on the text buffer.
  int m_mode = 0, m_x = 0, m_y = 0, m_cv = 0, m_cpos = 0, m_clr = 0, m_prev = 1;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, queue what the DUT must show.
  task automatic drive(input logic r, input int mx, input int my, input logic ml,
                       input logic kv, input int kc, input logic cr);
    int cx, cy, nx, ny, idx;
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.MOUSE_X_POS  = 10'(mx);
    bus.MOUSE_Y_POS  = 9'(my);
    bus.mouse_left   = ml;
    bus.key_valid    = kv;
    bus.key_code     = 3'(kc);
    bus.commit_ready = cr;

    if (r) begin
      m_mode = 0; m_x = 0; m_y = 0; m_cv = 0; m_cpos = 0; m_clr = 0; m_prev = 1;
    end else begin
      logic click;
      click  = ml && (m_prev == 0);
      m_prev = ml;
      m_clr  = 0;
      if (m_mode == 0) begin
        cx = mx / 32;
        cy = my / 32;
        if (click && cx < COLS && cy < ROWS) begin
          m_x = cx; m_y = cy; m_mode = 1; m_clr = 1;
        end
      end else if (m_mode == 1) begin
        if (kv) begin
          nx = m_x; ny = m_y;
          case (kc)
            1: ny = (m_y > 0) ? m_y - 1 : 0;
            2: ny = (m_y < ROWS - 1) ? m_y + 1 : ROWS - 1;
            3: nx = (m_x > 0) ? m_x - 1 : 0;
            4: nx = (m_x < COLS - 1) ? m_x + 1 : COLS - 1;
            5: begin m_mode = 2; m_cv = 1; m_cpos = m_y * 32 + m_x; end
            6: begin m_mode = 0; m_clr = 1; end
            default: ;
          endcase
          if (nx != m_x || ny != m_y) m_clr = 1;
          m_x = nx; m_y = ny;
        end
      end else begin
        if (cr) begin
          idx  = (m_y * COLS + m_x + 1) % (COLS * ROWS);
          m_x  = idx % COLS;
          m_y  = idx / COLS;
          m_mode = 0; m_cv = 0; m_clr = 1;
        end
      end
    end

    e.pos  = 9'(m_y * 32 + m_x);
    e.ed   = (m_mode != 0);
    e.cv   = 1'(m_cv);
    e.cpos = 9'(m_cpos);
    e.clr  = 1'(m_clr);
    exp_q.push_back(e);
  endtask

  // Spot check of the visible cursor state right after the next edge.
  task automatic check_now(input string name, input int pos, input int ed, input int cv);
    @(posedge clk);
    #2;
    cmp({name, "_pos"}, int'(bus.writing_block_pos), pos);
    cmp({name, "_editing"}, int'(bus.editing), ed);
    cmp({name, "_commit_valid"}, int'(bus.commit_valid), cv);
  endtask

  // Monitor: every edge that has a queued expectation is compared in full.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("writing_block_pos", int'(bus.writing_block_pos), int'(e.pos));
        cmp("editing",           int'(bus.editing),           int'(e.ed));
        cmp("commit_valid",      int'(bus.commit_valid),      int'(e.cv));
        cmp("commit_pos",        int'(bus.commit_pos),        int'(e.cpos));
        cmp("canvas_clear",      int'(bus.canvas_clear),      int'(e.clr));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.MOUSE_X_POS = '0; bus.MOUSE_Y_POS = '0; bus.mouse_left = 1'b0;
    bus.key_valid = 1'b0; bus.key_code = '0; bus.commit_ready = 1'b0;

    // Reset, then click at pixel (200,100) -> cell {3,6}.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 200, 100, 0, 0, 0, 0);
    drive(0, 200, 100, 1, 0, 0, 0);
    check_now("click_open", 'h066, 1, 0);
    drive(0, 200, 100, 1, 0, 0, 0);

    // Click while editing does not move the cursor.
    drive(0, 613, 453, 0, 0, 0, 0);
    drive(0, 613, 453, 1, 0, 0, 0);
    check_now("click_in_edit", 'h066, 1, 0);

    // Esc, then open the bottom-right cell and try to move past the edge.
    drive(0, 613, 453, 0, 1, 6, 1);
    check_now("esc", 'h066, 0, 0);
    drive(0, 613, 453, 1, 0, 0, 0);
    check_now("open_corner", 'h1D3, 1, 0);
    drive(0, 613, 453, 1, 1, 4, 0);
    check_now("sat_right", 'h1D3, 1, 0);
    drive(0, 613, 453, 1, 1, 2, 0);
    check_now("sat_down", 'h1D3, 1, 0);

    // Commit from the last cell wraps to {0,0}.
    drive(0, 613, 453, 1, 1, 5, 0);
    drive(0, 613, 453, 1, 0, 0, 1);
    check_now("wrap_commit", 'h000, 0, 0);

    // Open {2,19}, enter, hold ready low for five cycles then accept.
    drive(0, 608, 64, 0, 0, 0, 0);
    drive(0, 608, 64, 1, 0, 0, 0);
    drive(0, 608, 64, 0, 1, 5, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_now("commit_done", 'h060, 0, 0);

    // Out-of-grid click at (650,470) is ignored.
    drive(0, 650, 470, 1, 0, 0, 0);
    check_now("click_outside", 'h060, 0, 0);

    // Reset while a commit is pending.
    drive(0, 100, 100, 0, 0, 0, 0);
    drive(0, 100, 100, 1, 0, 0, 0);
    drive(0, 100, 100, 1, 1, 5, 0);
    drive(1, 100, 100, 1, 0, 0, 0);
    check_now("rst_in_commit", 'h000, 0, 0);

    // Randomized traffic, including occasional out-of-grid pointer and resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            int'($urandom_range(0, 700)),
            int'($urandom_range(0, 511)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
